// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Port 0 has fixed priority, and port 1 reads return two cycles after acceptance.
// Optional starvation guard for port 1: define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wren0,
  input  logic              wren1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  logic w_force1;
  logic w_acc;
  logic r_p1_rd;
  logic r_p1_port;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts consecutive denied cycles of port 1; saturates so the force stays asserted until granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!req1 || gnt1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + CNT_ONE;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  assign w_force1 = req1 && (r_starve_cnt == CNT_MAX);
`else
  assign w_force1 = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (w_force1) begin
      gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign w_acc = gnt0 | gnt1;

  // Memory drive stage; address/data hold when idle so only wren drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
      r_p1_rd      <= 1'b0;
      r_p1_port    <= 1'b0;
    end else if (w_acc) begin
      address_dmem <= gnt1 ? addr1 : addr0;
      data         <= gnt1 ? wdata1 : wdata0;
      wren         <= gnt1 ? wren1 : wren0;
      r_p1_rd      <= gnt1 ? !wren1 : !wren0;
      r_p1_port    <= gnt1;
    end else begin
      address_dmem <= address_dmem;
      data         <= data;
      wren         <= 1'b0;
      r_p1_rd      <= 1'b0;
      r_p1_port    <= r_p1_port;
    end
  end

  // Read-return stage: q_dmem answers the address driven in the previous cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= r_p1_rd && !r_p1_port;
      rvalid1 <= r_p1_rd && r_p1_port;
      rdata0  <= (r_p1_rd && !r_p1_port) ? q_dmem : rdata0;
      rdata1  <= (r_p1_rd && r_p1_port) ? q_dmem : rdata1;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, dmem word-address width.
REQ-002 Parameter DATA_W, default 32, dmem data width.
REQ-003 Parameter STARVE_MAX, default 8, consecutive denied cycles before port 1 is force-granted.
REQ-004 Port clock  in  1  single master clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Ports req0/req1  in  1  access request from port 0 (processor) and port 1 (loader/debug).
REQ-007 Ports wren0/wren1  in  1  write (1) or read (0) for the requested access.
REQ-008 Ports addr0/addr1  in  ADDR_W  access address.
REQ-009 Ports wdata0/wdata1  in  DATA_W  write data.
REQ-010 Ports gnt0/gnt1  out  1  combinational accept; access is taken at the rising edge where req and gnt are both high.
REQ-011 Ports rvalid0/rvalid1  out  1  one-cycle pulse; read data for that port is valid.
REQ-012 Ports rdata0/rdata1  out  DATA_W  registered read data.
REQ-013 Port address_dmem  out  ADDR_W, data  out  DATA_W, wren  out  1  registered dmem drive.
REQ-014 Port q_dmem  in  DATA_W  dmem read data; valid at the rising edge ending the cycle address_dmem is driven.

Function
REQ-015 At most one of gnt0/gnt1 SHALL be high in any cycle; gnt SHALL be low for a port whose req is low.
REQ-016 Default priority: port 0 over port 1 when both request.
REQ-017 Accepted access in cycle N SHALL drive address_dmem/data/wren in cycle N+1; with no acceptance in N, wren SHALL be 0 in N+1 and address_dmem/data SHALL hold.
REQ-018 Accepted read in cycle N SHALL produce rvalid and rdata = q_dmem on the accepting port in cycle N+2; rvalid SHALL never fire for writes.
REQ-019 Back-to-back acceptance, including alternating ports, SHALL sustain one access per cycle with no bubbles.
REQ-020 Memory access order SHALL equal acceptance order; no forwarding; read-after-write behaviour is the dmem's.
REQ-021 rdata of a port SHALL hold its last value when rvalid is low.
REQ-022 Requester SHALL hold req/wren/addr/wdata stable while req high and gnt low; arbiter behaviour is undefined otherwise.

Reset
REQ-023 While reset is high: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, address_dmem=0, data=0, wren=0, starvation counter=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight reads (no rvalid after release) and any write not yet driven to dmem.
REQ-025 First acceptance possible in the first cycle after reset deasserts.

Configuration
REQ-026 Macro DMEM_ARB_STARVE_EN compiles in a starvation guard.
REQ-027 With it: counter increments each cycle req1=1 and gnt1=0, clears on gnt1 or req1=0, saturates at STARVE_MAX.
REQ-028 With it: when the counter equals STARVE_MAX, port 1 SHALL be granted over port 0 that cycle.
REQ-029 Without it: strict fixed priority, no counter; port 1 may starve indefinitely.

Verification
REQ-030 Port 0 write addr 0x010 data 0xDEADBEEF, then read 0x010 -> wren=1 in cycle N+1, rvalid0 with rdata0=0xDEADBEEF two cycles after read acceptance.
REQ-031 req0 and req1 reads in same cycle -> gnt0 first, gnt1 next cycle; rvalid0 then rvalid1 on consecutive cycles, no bubble.
REQ-032 Port 0 requests every cycle, port 1 requests continuously, DMEM_ARB_STARVE_EN defined, STARVE_MAX=8 -> gnt1 on the 9th cycle of port 1 request; undefined -> gnt1 never while req0 high.
REQ-033 Reset asserted one cycle after a read acceptance -> no rvalid after release; all outputs 0 during reset.
REQ-034 Alternating-port stream of 16 reads -> 16 dmem accesses in 16 consecutive cycles, each rvalid on the correct port with matching data.
